// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter.
// State encoding, frame width and the round-robin pick.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  typedef logic [DATA_BITS-1:0] byte_t;

  // Requester that should own the next frame; meaningful only if any req is set.
  function automatic logic pick(
    input logic r0,
    input logic r1,
    input logic last
  );
    logic w;
    w = r1;
    if (r0 && r1) w = ~last;
    return w;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter for the UART transmitter.
// Counts clocks within one bit; bit_done marks the last clock of the bit.
module baud_tick_gen #(
  parameter int CLK_rate  = 100000000,
  parameter int Baud_rate = 9600
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart,
  output logic bit_done
);

  localparam int BIT_CYCLES = CLK_rate / Baud_rate;

  if (BIT_CYCLES < 2 || BIT_CYCLES > 65535) begin : g_bad_rate
    $error("baud_tick_gen: BIT_CYCLES out of range");
  end

  localparam logic [15:0] LAST = 16'(BIT_CYCLES - 1);

  logic [15:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (restart) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign bit_done = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester 8N1 UART transmitter with round-robin arbitration.
// Winner's byte is latched at grant; ack pulses the cycle after.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int CLK_rate  = 100000000,
  parameter int Baud_rate = 9600
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic [7:0] data0_i,
  input  logic [7:0] data1_i,
  output logic       ack0_o,
  output logic       ack1_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic       grant_o
);

  tx_state_e   state_q, state_d;
  byte_t       data_q, data_d;
  logic [2:0]  idx_q, idx_d;
  logic        grant_q, grant_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        bit_done;
  logic        restart;
  logic        win;

  // Counter is held at zero while idle so every bit starts from 0.
  assign restart = (state_q == IDLE) | bit_done;

  baud_tick_gen #(
    .CLK_rate (CLK_rate),
    .Baud_rate(Baud_rate)
  ) u_baud (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .restart (restart),
    .bit_done(bit_done)
  );

  assign win = pick(req0_i, req1_i, grant_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      grant_q <= 1'b1;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0_i || req1_i) begin
          grant_d = win;
          data_d  = win ? data1_i : data0_i;
          idx_d   = '0;
          ack0_d  = ~win;
          ack1_d  = win;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx_q == 3'(DATA_BITS - 1)) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_o = 1'b1;
    unique case (state_q)
      START:   tx_o = 1'b0;
      DATA:    tx_o = data_q[idx_q];
      default: tx_o = 1'b1;
    endcase
  end

  assign busy_o  = (state_q != IDLE);
  assign ack0_o  = ack0_q;
  assign ack1_o  = ack1_q;
  assign grant_o = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter at 16 clocks per bit.
// Bytes are queued at ack and checked by a line monitor.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [7:0] d0 = 8'h00;
  logic [7:0] d1 = 8'h00;
  logic       ack0, ack1, tx, busy, grant;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];

  uart_tx_arbiter #(
    .CLK_rate (160),
    .Baud_rate(10)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .req0_i (req0),
    .req1_i (req1),
    .data0_i(d0),
    .data1_i(d1),
    .ack0_o (ack0),
    .ack1_o (ack1),
    .tx_o   (tx),
    .busy_o (busy),
    .grant_o(grant)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Decodes one frame; the start bit was seen on the current negedge.
  task automatic rx_frame;
    logic [7:0] b;
    int bad;
    logic want;
    b = 8'h00;
    bad = 0;
    for (int k = 0; k < 160; k++) begin
      if (k > 0) @(negedge clk);
      if (rst_n !== 1'b1) return;
      if (busy !== 1'b1) bad++;
      if (k < 16) want = 1'b0;
      else if (k >= 144) want = 1'b1;
      else begin
        if ((k - 16) % 16 == 0) b[(k-16)/16] = tx;
        want = b[(k-16)/16];
      end
      if (tx !== want) bad++;
    end
    chk("frame_shape", bad, 0);
    chk("frame_queued", int'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) chk("frame_byte", b, exp_q.pop_front());
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) rx_frame();
    end
  end

  // who: 0/1 single ack, 2 both, -1 timeout
  task automatic wait_ack(output int who);
    who = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        who = (ack0 && ack1) ? 2 : (ack1 ? 1 : 0);
        break;
      end
    end
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
  endtask

  task automatic wait_idle;
    int n;
    count_busy(n);
    chk("idle_reached", busy, 0);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       r0;
    logic       r1;
    logic [7:0] dd0;
    logic [7:0] dd1;
    int         exp_g;
    logic [7:0] exp_b;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int who, n, t0, act;

    tbl[0] = '{1'b1, 1'b0, 8'hA5, 8'h00, 0, 8'hA5};
    tbl[1] = '{1'b0, 1'b1, 8'h00, 8'h3C, 1, 8'h3C};
    tbl[2] = '{1'b1, 1'b1, 8'h11, 8'h22, 0, 8'h11};
    tbl[3] = '{1'b1, 1'b1, 8'h33, 8'h44, 1, 8'h44};
    tbl[4] = '{1'b1, 1'b1, 8'h55, 8'h66, 0, 8'h55};
    tbl[5] = '{1'b0, 1'b1, 8'h77, 8'h88, 1, 8'h88};
    tbl[6] = '{1'b0, 1'b1, 8'h99, 8'hAA, 1, 8'hAA};
    tbl[7] = '{1'b1, 1'b1, 8'hBB, 8'hCC, 0, 8'hBB};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_grant", grant, 1);
    tick();
    rst_n = 1'b1;
    act = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) act++;
    end
    chk("release_quiet", act, 0);

    foreach (tbl[i]) begin
      tick();
      req0 = tbl[i].r0;
      req1 = tbl[i].r1;
      d0 = tbl[i].dd0;
      d1 = tbl[i].dd1;
      wait_ack(who);
      chk("vec_ack", who, tbl[i].exp_g);
      chk("vec_grant", grant, tbl[i].exp_g);
      exp_q.push_back(tbl[i].exp_b);
      tick();
      req0 = 1'b0;
      req1 = 1'b0;
      d0 = ~d0;
      d1 = ~d1;
      @(negedge clk);
      chk("vec_ack_pulse", int'(ack0 | ack1), 0);
      count_busy(n);
      chk("vec_busy_len", n + 2, 160);
    end

    // Both requesting out of reset, then back-to-back.
    tick();
    rst_n = 1'b0;
    req0 = 1'b1;
    req1 = 1'b1;
    d0 = 8'h01;
    d1 = 8'h80;
    tick();
    rst_n = 1'b1;
    wait_ack(who);
    chk("b2b_first", who, 0);
    t0 = cyc;
    exp_q.push_back(8'h01);
    tick();
    req0 = 1'b0;
    wait_ack(who);
    chk("b2b_second", who, 1);
    chk("b2b_spacing", cyc - t0, 161);
    exp_q.push_back(8'h80);
    tick();
    req1 = 1'b0;
    wait_idle();

    // Requester 1 held high continuously.
    tick();
    req1 = 1'b1;
    d1 = 8'h3C;
    for (int j = 0; j < 3; j++) begin
      wait_ack(who);
      chk("hold_ack", who, 1);
      chk("hold_grant", grant, 1);
      if (j > 0) chk("hold_spacing", cyc - t0, 161);
      t0 = cyc;
      exp_q.push_back(8'h3C);
    end
    tick();
    req1 = 1'b0;
    wait_idle();

    // Request arriving mid-frame is held off.
    tick();
    req1 = 1'b1;
    d1 = 8'h5A;
    wait_ack(who);
    chk("late_first", who, 1);
    t0 = cyc;
    exp_q.push_back(8'h5A);
    tick();
    req1 = 1'b0;
    repeat (38) @(posedge clk);
    #1;
    req0 = 1'b1;
    d0 = 8'hC3;
    wait_ack(who);
    chk("late_second", who, 0);
    chk("late_spacing", cyc - t0, 161);
    exp_q.push_back(8'hC3);
    tick();
    req0 = 1'b0;
    wait_idle();

    // Reset mid-frame aborts silently.
    tick();
    req0 = 1'b1;
    d0 = 8'h0F;
    wait_ack(who);
    chk("abort_ack", who, 0);
    tick();
    req0 = 1'b0;
    repeat (48) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    chk("abort_grant", grant, 1);
    repeat (3) tick();
    rst_n = 1'b1;
    act = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || ack0 || ack1) act++;
    end
    chk("abort_quiet", act, 0);

    tick();
    req0 = 1'b1;
    req1 = 1'b1;
    d0 = 8'hE7;
    d1 = 8'h18;
    wait_ack(who);
    chk("post_rst_rr", who, 0);
    exp_q.push_back(8'hE7);
    tick();
    req0 = 1'b0;
    req1 = 1'b0;
    wait_idle();

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter CLK_rate, default 100000000, input clock frequency in Hz.
REQ-002 SHALL have parameter Baud_rate, default 9600, serial bit rate in bit/s.
REQ-003 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req0_i / req1_i  input  1  requester 0/1 wants to send a byte.
REQ-006 SHALL have ports data0_i / data1_i  input  8  byte offered by requester 0/1.
REQ-007 SHALL have ports ack0_o / ack1_o  output  1  one-cycle pulse: byte latched, requester may release.
REQ-008 SHALL have port tx_o  output  1  serial line, idle high, 8N1 framing.
REQ-009 SHALL have port busy_o  output  1  high while a frame is on the line.
REQ-010 SHALL have port grant_o  output  1  index of requester owning the current/last frame.

Function
REQ-011 SHALL use BIT_CYCLES = CLK_rate/Baud_rate (integer division), full bit period; 10416 at defaults.
REQ-012 SHALL use a 16-bit bit-period counter; counter restarts at 0 on entry to every bit; bit ends when counter == BIT_CYCLES-1.
REQ-013 SHALL implement states IDLE, START, DATA, STOP.
REQ-014 IDLE: tx_o=1, busy_o=0; on an edge with any req sampled high, latch winner's data, go START.
REQ-015 Arbitration: single request wins; both high -> requester != grant_o wins (round robin).
REQ-016 ack of winner SHALL be high exactly the one cycle following the latching edge; loser gets no ack.
REQ-017 START: tx_o=0 for BIT_CYCLES clocks, then DATA with bit index 0.
REQ-018 DATA: tx_o=latched bit[index], LSB first, BIT_CYCLES clocks per bit; after index 7 go STOP.
REQ-019 STOP: tx_o=1 for BIT_CYCLES clocks, then IDLE.
REQ-020 busy_o SHALL be high in START, DATA, STOP; frame length exactly 10*BIT_CYCLES clocks.
REQ-021 Back-to-back: a request pending at STOP end is granted on the next IDLE edge; inter-frame gap exactly 1 clock of tx_o=1.
REQ-022 Requests arriving while busy SHALL be held off (no ack) until IDLE; req dropped before ack sends nothing.
REQ-023 Input data changes after latching SHALL NOT affect the frame in flight.
REQ-024 Requester holds req and data stable until ack; req still high in cycle after ack is treated as a new request.

Reset
REQ-025 rst_ni low SHALL immediately force: state IDLE, tx_o=1, busy_o=0, ack0_o=ack1_o=0, grant_o=1, counter=0, bit index=0.
REQ-026 Reset mid-frame SHALL abort the frame without ack or further line activity; first grant after reset goes to requester 0 if both request.
REQ-027 Release of rst_ni SHALL NOT by itself produce a frame.

Structure
REQ-028 Package uart_pkg SHALL hold the state enum type and DATA_BITS=8 constant.
REQ-029 Sub-module baud_tick_gen SHALL hold the bit-period counter (inputs clk_i, rst_ni, restart; output bit_done), parameterised by CLK_rate, Baud_rate.
REQ-030 Elaboration SHALL fail if BIT_CYCLES < 2 or BIT_CYCLES > 65535.

Verification (CLK_rate=160, Baud_rate=10, BIT_CYCLES=16)
REQ-031 req0_i=1, data0_i=0xA5 -> ack0_o pulse 1 clk; tx_o: 16 clk low, bits 1,0,1,0,0,1,0,1 x16 clk each, 16 clk high; busy_o high 160 clk.
REQ-032 req0_i and req1_i high from reset, data 0x01/0x80 -> ack0 first, frame 0x01, 1-clk gap, ack1, frame 0x80.
REQ-033 req1_i held high continuously, data1_i=0x3C -> repeated 0x3C frames, ack1 every 161 clk, grant_o stays 1.
REQ-034 req0_i asserted 40 clk into a req1 frame -> no ack0 until frame end; ack0 at clk 161 after ack1.
REQ-035 rst_ni low at clk 50 of a frame -> tx_o=1, busy_o=0 same cycle; after release, no activity without req.
REQ-036 data0_i changed 0x55->0xFF one clk after ack0 -> line carries 0x55.
